// File: rtl/exp_sched_pkg.sv
// Shared types and widths for the exponential-unit scheduler.
package exp_sched_pkg;

    // Operand handed to the exponential unit
    localparam int X_W    = 16;
    // Result integer and fractional parts returned by the unit
    localparam int INT_W  = 2;
    localparam int FRAC_W = 16;

    // Job sequencing: pick a requester, kick the unit, wait, deliver
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request at ptr, ptr+1, ... wrapping modulo N_REQ.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    // Slot k positions past the pointer; ptr is always kept below N_REQ.
    function automatic logic [IDX_W-1:0] slot(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return IDX_W'(s);
    endfunction

    // Scan from the pointer and keep only the first hit.
    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any && req[slot(ptr, k)]) begin
                any                 = 1'b1;
                index               = slot(ptr, k);
                grant[slot(ptr, k)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exp_scheduler.sv
// Shares one exponential unit among N_REQ requesters, one job at a time,
// with round-robin arbitration and a WAIT timeout that returns an error.
module exp_scheduler
    import exp_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [X_W*N_REQ-1:0]   req_x,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [INT_W-1:0]       rsp_intpart,
    output logic [FRAC_W-1:0]      rsp_fracpart,
    output logic                   rsp_err,
    output logic                   exp_start,
    output logic [X_W-1:0]         exp_x,
    input  logic                   exp_done,
    input  logic [INT_W-1:0]       exp_intpart,
    input  logic [FRAC_W-1:0]      exp_fracpart
);

    localparam int IDX_W = $clog2(N_REQ);
    // One spare bit so the incremented count can reach TIMEOUT without wrapping
    localparam int CNT_W = $clog2(TIMEOUT + 1) + 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               start_q, start_d;
    logic [N_REQ-1:0]   rv_q, rv_d;
    logic               err_q, err_d;
    logic [INT_W-1:0]   ip_q, ip_d;
    logic [FRAC_W-1:0]  fp_q, fp_d;

    logic [N_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [X_W-1:0]     sel_x;
    logic [N_REQ-1:0]   id_onehot;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               tmo_hit;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .index (pick_idx),
        .any   (pick_any)
    );

    // Operand of the requester the picker chose this cycle.
    always_comb begin
        sel_x = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_x = req_x[X_W*i +: X_W];
            end
        end
    end

    // Owner of the running job as a one-hot vector for the response pulse.
    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (id_q == IDX_W'(i)) begin
                id_onehot[i] = 1'b1;
            end
        end
    end

    assign cnt_nxt = cnt_q + CNT_W'(1);
    assign tmo_hit = (cnt_nxt == CNT_W'(TIMEOUT));

    // Next-state and next-output logic; every output is registered so the
    // pulses line up: ack during START, exp_start on the first WAIT cycle,
    // rsp_valid during RESP.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        start_d = 1'b0;
        rv_d    = '0;
        err_d   = 1'b0;
        ip_d    = ip_q;
        fp_d    = fp_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    id_d    = pick_idx;
                    x_d     = sel_x;
                    ack_d   = pick_grant;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                start_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_nxt;
                // A completion arriving on the timeout cycle still counts as success
                if (exp_done) begin
                    ip_d    = exp_intpart;
                    fp_d    = exp_fracpart;
                    err_d   = 1'b0;
                    rv_d    = id_onehot;
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    ip_d    = '0;
                    fp_d    = '0;
                    err_d   = 1'b1;
                    rv_d    = id_onehot;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // Owner moves to the back of the queue
                if (id_q == IDX_W'(N_REQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = id_q + IDX_W'(1);
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            ptr_q   <= '0;
            x_q     <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            rv_q    <= '0;
            err_q   <= 1'b0;
            ip_q    <= '0;
            fp_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
            ip_q    <= ip_d;
            fp_q    <= fp_d;
        end
    end

    assign ack          = ack_q;
    assign exp_start    = start_q;
    assign exp_x        = x_q;
    assign rsp_valid    = rv_q;
    assign rsp_err      = err_q;
    assign rsp_intpart  = ip_q;
    assign rsp_fracpart = fp_q;

endmodule

// File: tb/tb_exp_scheduler.sv
// Bench for exp_scheduler: vector table of jobs, hand-written corner
// sequences, and a randomized run against a transaction-level model.
module tb_exp_scheduler;

    localparam int N   = 4;
    localparam int TMO = 255;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [16*N-1:0] req_x;
    logic [N-1:0]    ack;
    logic [N-1:0]    rsp_valid;
    logic [1:0]      rsp_intpart;
    logic [15:0]     rsp_fracpart;
    logic            rsp_err;
    logic            exp_start;
    logic [15:0]     exp_x;
    logic            exp_done;
    logic [1:0]      exp_intpart;
    logic [15:0]     exp_fracpart;

    int          n_chk;
    int          n_err;
    int          cyc;
    int          stub_cnt;
    bit          stub_en;
    logic [15:0] xs [N];

    typedef struct {
        logic [N-1:0] rq;
        int           id;
    } vec_t;
    vec_t tbl [9];

    exp_scheduler #(
        .N_REQ   (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_x        (req_x),
        .ack          (ack),
        .rsp_valid    (rsp_valid),
        .rsp_intpart  (rsp_intpart),
        .rsp_fracpart (rsp_fracpart),
        .rsp_err      (rsp_err),
        .exp_start    (exp_start),
        .exp_x        (exp_x),
        .exp_done     (exp_done),
        .exp_intpart  (exp_intpart),
        .exp_fracpart (exp_fracpart)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock; also plays the exponential unit (done 5 cycles after start).
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        exp_done = 1'b0;
        if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0 && stub_en) exp_done = 1'b1;
        end
        if (exp_start) stub_cnt = 5;
    endtask

    task automatic drive_x();
        for (int i = 0; i < N; i++) req_x[16*i +: 16] = xs[i];
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int rr_ref(input logic [N-1:0] rq, input int p);
        for (int k = 0; k < N; k++) begin
            if (rq[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic do_reset();
        rst      = 1'b1;
        req      = '0;
        exp_done = 1'b0;
        stub_cnt = 0;
        stub_en  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ack(output logic [N-1:0] a, output int lat);
        int n;
        tick();
        n = 1;
        while (ack == '0 && n < 40) begin
            tick();
            n++;
        end
        a   = ack;
        lat = n;
    endtask

    // Waits for rsp_valid; done_at >= 0 injects exp_done that many cycles in.
    task automatic wait_rsp(input int done_at, output logic [N-1:0] r, output int d, output int ov);
        int s;
        s  = cyc;
        ov = 0;
        tick();
        if (done_at >= 0 && cyc - s == done_at) exp_done = 1'b1;
        while (rsp_valid == '0 && cyc - s < 300) begin
            if (ack != '0) ov++;
            tick();
            if (done_at >= 0 && cyc - s == done_at) exp_done = 1'b1;
        end
        r = rsp_valid;
        d = cyc - s;
    endtask

    // mode 0: normal, 1: timeout (stub silent), 2: done on the timeout cycle
    task automatic run_job(input logic [N-1:0] rq, input int id, input int mode);
        logic [N-1:0] a, r;
        int           lat, d, ov;
        logic [15:0]  xe;
        req = rq;
        wait_ack(a, lat);
        check("ack_id", 64'(a), 64'(onehot(id)));
        check("ack_latency", 64'(lat), 64'd1);
        xe  = xs[id];
        req = '0;
        tick();
        check("exp_start", 64'(exp_start), 64'd1);
        check("exp_x", 64'(exp_x), 64'(xe));
        check("ack_pulse", 64'(ack), 64'd0);
        wait_rsp((mode == 2) ? 254 : -1, r, d, ov);
        check("rsp_valid", 64'(r), 64'(onehot(id)));
        check("rsp_delay", 64'(d), (mode == 0) ? 64'd6 : 64'd255);
        check("overlap_ack", 64'(ov), 64'd0);
        if (mode == 1) begin
            check("rsp_err", 64'(rsp_err), 64'd1);
            check("rsp_result", {46'd0, rsp_intpart, rsp_fracpart}, 64'd0);
        end else begin
            check("rsp_err", 64'(rsp_err), 64'd0);
            check("rsp_result", {46'd0, rsp_intpart, rsp_fracpart}, {46'd0, 2'd2, 16'hB7E1});
        end
        tick();
        check("rsp_pulse", {62'd0, rsp_valid != '0, rsp_err}, 64'd0);
    endtask

    initial begin
        logic [N-1:0] a, r, preq, e_ack, e_rsp;
        logic [15:0]  px [N];
        logic [15:0]  ox;
        bit           e_start;
        int           lat, d, ov, m_ptr, busy_until, start_at, owner;

        rst = 1'b0; req = '0; req_x = '0; exp_done = 1'b0;
        exp_intpart = 2'd2; exp_fracpart = 16'hB7E1;
        stub_en = 1'b1; stub_cnt = 0; n_chk = 0; n_err = 0; cyc = 0;
        for (int i = 0; i < N; i++) xs[i] = '0;

        tbl[0] = '{4'b0001, 0}; tbl[1] = '{4'b1111, 1}; tbl[2] = '{4'b0011, 0};
        tbl[3] = '{4'b1000, 3}; tbl[4] = '{4'b0110, 1}; tbl[5] = '{4'b0100, 2};
        tbl[6] = '{4'b0111, 0}; tbl[7] = '{4'b1010, 1}; tbl[8] = '{4'b1010, 3};

        // Reset state, asserted asynchronously before any clock edge
        #3 rst = 1'b1;
        #1;
        check("rst_async_ctrl", {58'd0, ack, exp_start, rsp_err}, 64'd0);
        check("rst_async_data", {30'd0, rsp_valid, rsp_intpart, rsp_fracpart, exp_x}, 64'd0);
        tick();
        tick();
        check("rst_held", {20'd0, ack, rsp_valid, rsp_intpart, rsp_fracpart, rsp_err, exp_start, exp_x}, 64'd0);
        rst = 1'b0;

        // Table of single jobs walking the round-robin pointer
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < N; i++)
                xs[i] = (k == 0 && i == 0) ? 16'd10 : 16'(16'h4000 + k * 257 + i * 4369);
            drive_x();
            run_job(tbl[k].rq, tbl[k].id, 0);
        end

        // Spurious exp_done while idle
        exp_done = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("spurious_done", {55'd0, ack, exp_start, rsp_valid}, 64'd0);
        end
        run_job(4'b0001, 0, 0);

        // Contention: all requests held from reset
        do_reset();
        req = 4'b1111;
        for (int j = 0; j < N; j++) begin
            wait_ack(a, lat);
            check("contend_ack", 64'(a), 64'(onehot(j)));
            wait_rsp(-1, r, d, ov);
            check("contend_rsp", 64'(r), 64'(onehot(j)));
            check("contend_overlap", 64'(ov), 64'd0);
        end
        req = '0;
        tick();

        // Fairness: req[0] held throughout, req[2] raised during job 0
        do_reset();
        req = 4'b0001;
        wait_ack(a, lat);
        check("fair_first", 64'(a), 64'(onehot(0)));
        tick();
        tick();
        req = 4'b0101;
        wait_rsp(-1, r, d, ov);
        wait_ack(a, lat);
        check("fair_second", 64'(a), 64'(onehot(2)));
        req = 4'b0001;
        wait_rsp(-1, r, d, ov);
        wait_ack(a, lat);
        check("fair_third", 64'(a), 64'(onehot(0)));
        req = '0;
        wait_rsp(-1, r, d, ov);
        tick();

        // Timeout, recovery, and done colliding with the timeout cycle
        for (int i = 0; i < N; i++) xs[i] = 16'(16'h7100 + i);
        drive_x();
        stub_en = 1'b0;
        run_job(4'b0010, 1, 1);
        stub_en = 1'b1;
        run_job(4'b1000, 3, 0);
        stub_en = 1'b0;
        run_job(4'b0010, 1, 2);
        stub_en = 1'b1;

        // Reset three cycles after exp_start, with pointer parked at 2
        xs[2] = 16'h1234;
        drive_x();
        req = 4'b0100;
        wait_ack(a, lat);
        check("rstjob_ack", 64'(a), 64'(onehot(2)));
        tick();
        check("rstjob_start", 64'(exp_start), 64'd1);
        tick(); tick(); tick();
        #2 rst = 1'b1;
        stub_cnt = 0;
        #1;
        check("rst_mid_outputs", {20'd0, ack, rsp_valid, rsp_intpart, rsp_fracpart, rsp_err, exp_start, exp_x}, 64'd0);
        tick();
        check("rst_mid_no_rsp", 64'(rsp_valid), 64'd0);
        rst = 1'b0;
        exp_done = 1'b0;
        req = 4'b0101;
        wait_ack(a, lat);
        check("rst_ptr_zero", 64'(a), 64'(onehot(0)));
        req = 4'b0100;
        wait_rsp(-1, r, d, ov);
        check("rst_after_rsp0", 64'(r), 64'(onehot(0)));
        wait_ack(a, lat);
        check("rst_reack", 64'(a), 64'(onehot(2)));
        req = '0;
        wait_rsp(-1, r, d, ov);
        check("rst_after_rsp2", 64'(r), 64'(onehot(2)));
        tick();

        // Randomized traffic against a transaction-level model
        do_reset();
        m_ptr = 0; busy_until = cyc - 1; start_at = -100; owner = 0; ox = '0;
        for (int it = 0; it < 1500; it++) begin
            preq = req;
            px   = xs;
            tick();
            e_ack = '0;
            e_rsp = '0;
            if (cyc - 1 > busy_until && preq != '0) begin
                owner      = rr_ref(preq, m_ptr);
                e_ack      = onehot(owner);
                ox         = px[owner];
                start_at   = cyc + 1;
                busy_until = cyc + 7;
            end
            e_start = (cyc == start_at);
            if (cyc == busy_until) e_rsp = onehot(owner);
            check("rand_ctrl", {55'd0, ack, exp_start, rsp_valid}, {55'd0, e_ack, e_start, e_rsp});
            if (e_start) check("rand_exp_x", 64'(exp_x), 64'(ox));
            if (e_rsp != '0) begin
                check("rand_result", {45'd0, rsp_err, rsp_intpart, rsp_fracpart}, {45'd0, 1'b0, 2'd2, 16'hB7E1});
                m_ptr = (owner + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    if ($urandom_range(1) == 1) req[i] = 1'b0;
                    xs[i] = 16'($urandom);
                end else if (!req[i] && $urandom_range(3) == 0) begin
                    req[i] = 1'b1;
                    xs[i]  = 16'($urandom);
                end
            end
            drive_x();
            if (cyc > busy_until && $urandom_range(7) == 0) exp_done = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/exp_scheduler.md
EXP_SCHEDULER -- requirements
Module: exp_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing one exponential unit (2..8).
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum cycles in WAIT before the job is aborted.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 req  input  N_REQ  SHALL carry per-requester job requests, held high until ack.
REQ-006 req_x  input  16*N_REQ  SHALL carry the operand per requester; slice i is bits [16*i+15:16*i].
REQ-007 ack  output  N_REQ  SHALL be a one-cycle one-hot pulse marking acceptance of a request.
REQ-008 rsp_valid  output  N_REQ  SHALL be a one-cycle one-hot pulse marking result delivery to the owner.
REQ-009 rsp_intpart  output  2  SHALL be the result integer part, valid with rsp_valid.
REQ-010 rsp_fracpart  output  16  SHALL be the result fractional part, valid with rsp_valid.
REQ-011 rsp_err  output  1  SHALL be high with rsp_valid when the job timed out.
REQ-012 exp_start  output  1  SHALL be the one-cycle start pulse to the exponential unit.
REQ-013 exp_x  output  16  SHALL be the operand to the exponential unit, stable from exp_start until leaving WAIT.
REQ-014 exp_done, exp_intpart[1:0], exp_fracpart[15:0]  input  SHALL be the exponential unit's completion pulse and result.

Function
REQ-015 FSM states SHALL be IDLE, START, WAIT, RESP.
REQ-016 IDLE: with any req bit high, SHALL select one requester round-robin starting at pointer ptr, latch its id and req_x slice, pulse ack[id], go to START next cycle.
REQ-017 Round-robin: SHALL pick the first set req bit at index ptr, ptr+1, ... modulo N_REQ.
REQ-018 START: SHALL assert exp_start for exactly one cycle, clear the timeout counter, go to WAIT.
REQ-019 WAIT: on exp_done high SHALL latch exp_intpart/exp_fracpart, clear the error flag, go to RESP.
REQ-020 WAIT: timeout counter SHALL increment each cycle; when it equals TIMEOUT with no exp_done, SHALL set the error flag, results zero, go to RESP.
REQ-021 exp_done and timeout in the same cycle SHALL resolve as exp_done (no error).
REQ-022 RESP: SHALL pulse rsp_valid[id] for one cycle with latched results and rsp_err, set ptr = (id+1) mod N_REQ, return to IDLE.
REQ-023 Minimum turnaround: ack at cycle t, exp_start at t+1, rsp_valid one cycle after the exp_done sample, IDLE on the following cycle.
REQ-024 exp_done outside WAIT SHALL be ignored; req changes after ack SHALL not affect the running job.
REQ-025 A requester still high in IDLE after its own RESP SHALL be served again only after all other pending requesters.
REQ-026 At most one job SHALL be in flight; ack SHALL not pulse outside IDLE.

Reset
REQ-027 rst high SHALL force IDLE, ptr=0, ack=0, rsp_valid=0, rsp_err=0, rsp_intpart=0, rsp_fracpart=0, exp_start=0, exp_x=0, counter=0, asynchronously.
REQ-028 rst mid-job SHALL abort the job with no rsp_valid; the requester SHALL re-request.

Structure
REQ-029 Package exp_sched_pkg SHALL hold the state encoding, operand width 16, integer width 2, fraction width 16.
REQ-030 Round-robin selection SHALL be a sub-module rr_picker (inputs req, ptr; outputs one-hot grant, index, any).

Verification (exponential unit stub: fixed latency 5 cycles, returns intpart=2, fracpart=16'hB7E1)
REQ-031 Single: req=4'b0001, x0=16'd10 -> ack[0] next cycle, exp_start one cycle later with exp_x=10, rsp_valid[0] with intpart=2, fracpart=16'hB7E1.
REQ-032 Contention: req=4'b1111 held after reset -> acks in order 0,1,2,3; four rsp_valid pulses in that order; never two jobs overlapping.
REQ-033 Fairness: req[0] held continuously, req[2] raised during job 0 -> next ack goes to 2 before 0 again.
REQ-034 Timeout: stub never asserts exp_done, TIMEOUT=255 -> rsp_valid[id] with rsp_err=1 and zero results at 255 cycles in WAIT; next job proceeds normally.
REQ-035 Reset mid-WAIT: rst pulsed 3 cycles after exp_start -> all outputs 0 immediately, no rsp_valid, ptr=0; held req re-acked after rst release.
REQ-036 Spurious done: exp_done pulsed in IDLE -> no rsp_valid, state unchanged.
